// File: rtl/a2d_intf.sv
// a2d_intf: round-robin SPI front end for an 8-channel 12-bit ADC.
// Define A2D_DONE_PULSE_EN to add the cnv_cmplt round-complete pulse.
module a2d_intf #(
    parameter int CNV_PER_W = 14
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MISO,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    output logic [11:0] batt,
    output logic [11:0] curr,
    output logic [11:0] brake,
    output logic [11:0] torque
`ifdef A2D_DONE_PULSE_EN
    ,
    output logic        cnv_cmplt
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        GAP,
        READ
    } state_t;

    state_t               state;
    logic [CNV_PER_W-1:0] cnt;
    logic                 trig;
    logic [1:0]           ptr;
    logic [2:0]           chnl;
    logic [15:0]          cmd;
    logic                 strt;

    logic                 busy;
    logic [4:0]           div;
    logic [4:0]           fcnt;
    logic [15:0]          tx;
    logic [11:0]          rx;
    logic                 fall;
    logic                 rise;
    logic                 done;

    assign trig = &cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    always_comb begin
        chnl = 3'd0;
        unique case (ptr)
            2'd0: chnl = 3'd0;
            2'd1: chnl = 3'd1;
            2'd2: chnl = 3'd3;
            2'd3: chnl = 3'd4;
        endcase
    end

    assign cmd = {2'b00, chnl, 11'h000};

    // Divider starts one count before the porch so SCLK stays high 8 clks
    assign SCLK = div[4];
    assign MOSI = tx[15];
    assign fall = busy && (div == 5'b11111);
    assign rise = busy && (div == 5'b01111);
    assign done = fall && (fcnt == 5'd16);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            SS_n <= 1'b1;
            div  <= 5'b10111;
            fcnt <= 5'd0;
            tx   <= 16'h0000;
            rx   <= 12'h000;
        end else if (strt && !busy) begin
            busy <= 1'b1;
            div  <= 5'b10111;
            fcnt <= 5'd0;
            tx   <= cmd;
        end else if (done) begin
            busy <= 1'b0;
            SS_n <= 1'b1;
            div  <= 5'b10111;
        end else if (busy) begin
            SS_n <= 1'b0;
            div  <= div + 5'd1;
            if (fall) begin
                fcnt <= fcnt + 5'd1;
                if (fcnt != 5'd0)
                    tx <= {tx[14:0], 1'b0};
            end
            if (rise)
                rx <= {rx[10:0], MISO};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            strt   <= 1'b0;
            ptr    <= 2'd0;
            batt   <= 12'h000;
            curr   <= 12'h000;
            brake  <= 12'h000;
            torque <= 12'h000;
        end else begin
            strt <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (trig) begin
                        state <= CMD;
                        strt  <= 1'b1;
                    end
                end
                CMD: begin
                    if (done) begin
                        state <= GAP;
                        strt  <= 1'b1;
                    end
                end
                GAP: state <= READ;
                READ: begin
                    if (done) begin
                        unique case (ptr)
                            2'd0: batt   <= rx;
                            2'd1: curr   <= rx;
                            2'd2: brake  <= rx;
                            2'd3: torque <= rx;
                        endcase
                        ptr   <= ptr + 2'd1;
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

`ifdef A2D_DONE_PULSE_EN
    logic t_upd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_upd     <= 1'b0;
            cnv_cmplt <= 1'b0;
        end else begin
            t_upd     <= (state == READ) && done && (ptr == 2'd3);
            cnv_cmplt <= t_upd;
        end
    end
`endif

endmodule

// File: tb/tb_a2d_intf.sv
// Bench for a2d_intf: SPI ADC slave model plus round-robin scoreboard.
// Builds with or without A2D_DONE_PULSE_EN.
module tb_a2d_intf;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        MISO  = 1'b0;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic [11:0] batt;
    logic [11:0] curr;
    logic [11:0] brake;
    logic [11:0] torque;
`ifdef A2D_DONE_PULSE_EN
    logic        cnv_cmplt;
    int          n_pulse = 0;
`endif

    a2d_intf #(.CNV_PER_W(11)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .MISO  (MISO),
        .SS_n  (SS_n),
        .SCLK  (SCLK),
        .MOSI  (MOSI),
        .batt  (batt),
        .curr  (curr),
        .brake (brake),
        .torque(torque)
`ifdef A2D_DONE_PULSE_EN
        ,
        .cnv_cmplt(cnv_cmplt)
`endif
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    logic [15:0] adc_val [8];
    logic [15:0] cmd_resp = 16'h0555;
    int          seq [4] = '{0, 1, 3, 4};
    logic [11:0] m_out [4] = '{default: 12'h000};
    int          m_ptr = 0;
    bit          rd_par = 1'b0;
    int          conv_n = 0;
    int          conv_end = 0;
    int          pulse_cyc = -10;
    logic [15:0] cap = 16'h0;
    logic [15:0] cmd_cap = 16'h0;
    logic [15:0] sword = 16'h0;
    logic [15:0] cmd_log [8][2];
    int          nrise = 0;
    int          nfall = 0;
    int          ch;
    logic [2:0]  chb;
    logic [15:0] exp_cmd;
    int          low_n = 0;
    int          gap_n = 0;
    bit          prev_ss = 1'b1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
    endtask

    task automatic wait_conv(input int n);
        int k = 0;
        int lim = 2100 * (n - conv_n) + 1200;
        while (conv_n < n && k < lim) begin
            @(negedge clk);
            k++;
        end
        chk("conv_timeout", 32'(conv_n >= n), 1);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ADC slave: shifts its word out on SCLK falls after the porch fall
    initial forever begin
        @(negedge SS_n or negedge SCLK);
        if (SCLK === 1'b1) begin
            nfall = 0;
            nrise = 0;
            cap   = 16'h0;
            sword = rd_par ? adc_val[cmd_cap[13:11]] : cmd_resp;
            MISO  = sword[15];
        end else if (SS_n === 1'b0) begin
            nfall++;
            if (nfall > 1) begin
                sword = sword << 1;
                MISO  = sword[15];
            end
        end
    end

    initial forever begin
        @(posedge SCLK);
        if (SS_n === 1'b0) begin
            nrise++;
            cap = {cap[14:0], MOSI};
        end
    end

    initial forever begin
        @(posedge SS_n);
        if (rst_n === 1'b1) begin
            chk("sclk_rises", nrise, 16);
            ch      = seq[m_ptr];
            chb     = 3'(ch);
            exp_cmd = {2'b00, chb, 11'h000};
            chk(rd_par ? "read_cmd" : "cmd_word", cap, exp_cmd);
            cmd_log[ch][rd_par] = cap;
            if (!rd_par) begin
                cmd_cap = cap;
                rd_par  = 1'b1;
            end else begin
                m_out[m_ptr] = adc_val[ch][11:0];
                if (m_ptr == 3)
                    pulse_cyc = cyc + 1;
                m_ptr    = (m_ptr + 1) % 4;
                rd_par   = 1'b0;
                conv_n++;
                conv_end = cyc;
            end
        end
    end

    initial forever begin
        @(negedge rst_n);
        for (int i = 0; i < 4; i++)
            m_out[i] = 12'h000;
        m_ptr     = 0;
        rd_par    = 1'b0;
        pulse_cyc = -10;
    end

    initial forever begin
        @(negedge clk);
        if (rst_n !== 1'b1) begin
            low_n   = 0;
            gap_n   = 0;
            prev_ss = 1'b1;
        end else begin
            chk("batt", batt, m_out[0]);
            chk("curr", curr, m_out[1]);
            chk("brake", brake, m_out[2]);
            chk("torque", torque, m_out[3]);
`ifdef A2D_DONE_PULSE_EN
            chk("cnv_cmplt", cnv_cmplt, 32'(cyc == pulse_cyc));
            if (cnv_cmplt === 1'b1)
                n_pulse++;
`endif
            if (SS_n === 1'b0) begin
                if (prev_ss && rd_par)
                    chk("ss_gap", gap_n, 2);
                low_n++;
            end else begin
                if (!prev_ss) begin
                    chk("ss_low", low_n, 520);
                    low_n = 0;
                    gap_n = 0;
                end
                gap_n++;
                chk("sclk_idle", SCLK, 1);
            end
            prev_ss = SS_n;
        end
    end

    initial begin
        int t0;
        int e1;
        int k;
        for (int i = 0; i < 8; i++)
            adc_val[i] = 16'h0000;
        adc_val[0] = 16'h0A98;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ss_n", SS_n, 1);
        chk("rst_sclk", SCLK, 1);
        chk("rst_mosi", MOSI, 0);
        chk("rst_batt", batt, 0);
        chk("rst_curr", curr, 0);
        chk("rst_brake", brake, 0);
        chk("rst_torque", torque, 0);
`ifdef A2D_DONE_PULSE_EN
        chk("rst_cnv_cmplt", cnv_cmplt, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        t0 = cyc;

        wait_conv(1);
        chk("conv1_latency", conv_end - t0, 3092);
        chk("lit_batt_a98", batt, 12'hA98);
        chk("lit_curr_0", curr, 12'h000);
        chk("lit_brake_0", brake, 12'h000);
        chk("lit_torque_0", torque, 12'h000);
        adc_val[0] = 16'h0123;
        adc_val[1] = 16'h0456;
        adc_val[3] = 16'h0789;
        adc_val[4] = 16'h0ABC;
        e1 = conv_end;

        wait_conv(2);
        chk("conv_period", conv_end - e1, 2048);
        wait_conv(5);
        chk("lit_batt_123", batt, 12'h123);
        chk("lit_curr_456", curr, 12'h456);
        chk("lit_brake_789", brake, 12'h789);
        chk("lit_torque_abc", torque, 12'hABC);
        chk("lit_ch4_cmd", cmd_log[4][0], 16'h2000);
        chk("lit_ch4_read", cmd_log[4][1], 16'h2000);
`ifdef A2D_DONE_PULSE_EN
        chk("pulse_count", n_pulse, 1);
`endif

        adc_val[1] = 16'hFFFF;
        wait_conv(6);
        chk("lit_curr_fff", curr, 12'hFFF);

        k = 0;
        while (!(rd_par && SS_n === 1'b0 && m_ptr == 2) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk("ch3_read_seen", 32'(k < 3000), 1);
        repeat (200) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ss_n", SS_n, 1);
        chk("mid_rst_sclk", SCLK, 1);
        chk("mid_rst_batt", batt, 0);
        chk("mid_rst_curr", curr, 0);
        chk("mid_rst_brake", brake, 0);
        chk("mid_rst_torque", torque, 0);
        @(negedge clk);
        rst_n = 1'b1;
        t0 = cyc;
        adc_val[0] = 16'h03C5;
        cmd_log[0][0] = 16'hFFFF;
        cmd_log[0][1] = 16'hFFFF;

        wait_conv(7);
        chk("rst_conv_latency", conv_end - t0, 3092);
        chk("lit_batt_3c5", batt, 12'h3C5);
        chk("lit_curr_after_rst", curr, 12'h000);
        chk("lit_ch0_cmd", cmd_log[0][0], 16'h0000);
        chk("lit_ch0_read", cmd_log[0][1], 16'h0000);

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
